// File: rtl/fc_operand_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : fc_operand_sequencer
// Purpose  : Operand-side sequencer for a 16-lane MAC/truncate/accumulate ALU
//            running a fully connected layer. For every output neuron it
//            walks the input chunks, fetches activation/weight/bias words,
//            drives them onto registered ALU operand buses, chains the ALU
//            result back as pre_data, and emits the finished neuron value on
//            a valid/ready stream.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk, rst_n              : clock (rising edge), synchronous active-low reset
//   start, n_chunks, n_out,
//   relu_en                 : layer launch pulse and configuration
//   busy, done              : layer status (busy level, done one-cycle pulse)
//   buf_rd_en, act_addr,
//   wgt_addr, bias_addr     : buffer read request (data returns next cycle)
//   act_rdata, wgt_rdata,
//   bias_rdata              : buffer read data
//   mula_bus, mulw_bus,
//   biase, pre_data,
//   biase_ena               : registered ALU operands
//   alu_result              : ALU truncated output
//   out_valid, out_ready,
//   out_data, out_idx       : neuron result stream
// ============================================================================
module fc_operand_sequencer #(
  parameter int ALU_LAT = 2,
  parameter int CHUNK_W = 8,
  parameter int NEUR_W  = 8,
  parameter int WADDR_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [CHUNK_W-1:0] n_chunks,
  input  logic [NEUR_W-1:0]  n_out,
  input  logic               relu_en,
  output logic               busy,
  output logic               done,
  output logic               buf_rd_en,
  output logic [CHUNK_W-1:0] act_addr,
  output logic [WADDR_W-1:0] wgt_addr,
  output logic [NEUR_W-1:0]  bias_addr,
  input  logic [255:0]       act_rdata,
  input  logic [255:0]       wgt_rdata,
  input  logic [15:0]        bias_rdata,
  output logic [255:0]       mula_bus,
  output logic [255:0]       mulw_bus,
  output logic [15:0]        biase,
  output logic [15:0]        pre_data,
  output logic               biase_ena,
  input  logic [15:0]        alu_result,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [15:0]        out_data,
  output logic [NEUR_W-1:0]  out_idx
);

  // Wait counter must hold the value ALU_LAT (WAIT lasts ALU_LAT+1 cycles).
  localparam int WCNT_W = (ALU_LAT < 1) ? 1 : $clog2(ALU_LAT + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LOAD  = 3'd2,
    S_WAIT  = 3'd3,
    S_EMIT  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t              state_q,    state_d;
  logic                busy_q,     busy_d;
  logic [CHUNK_W-1:0]  nchunks_q,  nchunks_d;
  logic [NEUR_W-1:0]   nout_q,     nout_d;
  logic                relu_q,     relu_d;
  logic [CHUNK_W-1:0]  chunk_q,    chunk_d;
  logic [NEUR_W-1:0]   neuron_q,   neuron_d;
  logic [WADDR_W-1:0]  wbase_q,    wbase_d;
  logic [WCNT_W-1:0]   wcnt_q,     wcnt_d;
  logic [15:0]         acc_q,      acc_d;
  logic [255:0]        mula_q,     mula_d;
  logic [255:0]        mulw_q,     mulw_d;
  logic [15:0]         biase_q,    biase_d;
  logic [15:0]         pre_q,      pre_d;
  logic                bena_q,     bena_d;

  logic                last_chunk;
  logic                last_neuron;

  assign last_chunk  = ((chunk_q + CHUNK_W'(1)) == nchunks_q);
  assign last_neuron = ((neuron_q + NEUR_W'(1)) == nout_q);

  always_comb begin
    state_d   = state_q;
    busy_d    = busy_q;
    nchunks_d = nchunks_q;
    nout_d    = nout_q;
    relu_d    = relu_q;
    chunk_d   = chunk_q;
    neuron_d  = neuron_q;
    wbase_d   = wbase_q;
    wcnt_d    = wcnt_q;
    acc_d     = acc_q;
    mula_d    = mula_q;
    mulw_d    = mulw_q;
    biase_d   = biase_q;
    pre_d     = pre_q;
    bena_d    = bena_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if ((n_chunks != '0) && (n_out != '0)) begin
            nchunks_d = n_chunks;
            nout_d    = n_out;
            relu_d    = relu_en;
            busy_d    = 1'b1;
            chunk_d   = '0;
            neuron_d  = '0;
            wbase_d   = '0;
            state_d   = S_FETCH;
          end else begin
            // Empty layer: nothing to compute, just acknowledge with done.
            state_d = S_DONE;
          end
        end
      end

      S_FETCH: begin
        state_d = S_LOAD;
      end

      S_LOAD: begin
        mula_d = act_rdata;
        mulw_d = wgt_rdata;
        if (chunk_q == '0) begin
          bena_d  = 1'b1;
          biase_d = bias_rdata;
          pre_d   = 16'h0000;
        end else begin
          bena_d  = 1'b0;
        end
        wcnt_d  = '0;
        state_d = S_WAIT;
      end

      S_WAIT: begin
        if (wcnt_q == WCNT_W'(ALU_LAT)) begin
          acc_d = alu_result;
          if (!last_chunk) begin
            pre_d   = alu_result;
            chunk_d = chunk_q + CHUNK_W'(1);
            state_d = S_FETCH;
          end else begin
            state_d = S_EMIT;
          end
        end else begin
          wcnt_d = wcnt_q + WCNT_W'(1);
        end
      end

      S_EMIT: begin
        if (out_ready) begin
          if (!last_neuron) begin
            neuron_d = neuron_q + NEUR_W'(1);
            chunk_d  = '0;
            // Running base replaces neuron*n_chunks; wraps mod 2^WADDR_W.
            wbase_d  = wbase_q + WADDR_W'(nchunks_q);
            state_d  = S_FETCH;
          end else begin
            state_d  = S_DONE;
          end
        end
      end

      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      busy_q    <= 1'b0;
      nchunks_q <= '0;
      nout_q    <= '0;
      relu_q    <= 1'b0;
      chunk_q   <= '0;
      neuron_q  <= '0;
      wbase_q   <= '0;
      wcnt_q    <= '0;
      acc_q     <= '0;
      mula_q    <= '0;
      mulw_q    <= '0;
      biase_q   <= '0;
      pre_q     <= '0;
      bena_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      busy_q    <= busy_d;
      nchunks_q <= nchunks_d;
      nout_q    <= nout_d;
      relu_q    <= relu_d;
      chunk_q   <= chunk_d;
      neuron_q  <= neuron_d;
      wbase_q   <= wbase_d;
      wcnt_q    <= wcnt_d;
      acc_q     <= acc_d;
      mula_q    <= mula_d;
      mulw_q    <= mulw_d;
      biase_q   <= biase_d;
      pre_q     <= pre_d;
      bena_q    <= bena_d;
    end
  end

  // Addresses and stream payload are forced to zero outside their strobe so
  // the interface idles at all-zero.
  assign buf_rd_en = (state_q == S_FETCH);
  assign act_addr  = buf_rd_en ? chunk_q : '0;
  assign wgt_addr  = buf_rd_en ? (wbase_q + WADDR_W'(chunk_q)) : '0;
  assign bias_addr = buf_rd_en ? neuron_q : '0;

  assign out_valid = (state_q == S_EMIT);
  assign out_data  = (!out_valid || (relu_q && acc_q[15])) ? 16'h0000 : acc_q;
  assign out_idx   = out_valid ? neuron_q : '0;

  assign busy      = busy_q;
  assign done      = (state_q == S_DONE);
  assign mula_bus  = mula_q;
  assign mulw_bus  = mulw_q;
  assign biase     = biase_q;
  assign pre_data  = pre_q;
  assign biase_ena = bena_q;

endmodule
`default_nettype wire
